// File: rtl/uart_ai_frame_bridge.sv
// uart_ai_frame_bridge
//   Collects a header-prefixed frame of DATA_W/8 UART bytes into one word for
//   the AI core. It then pulses the AI start and waits for a rising edge on AI
//   done, guarded by a watchdog. The result goes back MSB byte first. On a
//   watchdog expiry the AI core is reset and a single error byte is sent.
//   All outputs come straight from flops.
module uart_ai_frame_bridge #(
  parameter int unsigned DATA_W      = 64,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE,
  parameter int unsigned GAP_CYC     = 5_000_000,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned ARST_CYC    = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [7:0]        iRXD_DATA,
  input  logic              iRXD_Ready,
  output logic [7:0]        oTXD_DATA,
  output logic              oTXD_Start,
  input  logic              iTXD_Done,
  output logic [DATA_W-1:0] oAI_DATA,
  output logic              oAI_Start,
  input  logic [DATA_W-1:0] iAI_DATA,
  input  logic              iAI_Done,
  output logic              oAI_RSTn,
  output logic              oBusy,
  output logic [15:0]       oFrameCnt,
  output logic [7:0]        oErrCnt
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned CNT_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned ARST_W = (ARST_CYC > 1) ? $clog2(ARST_CYC) : 1;

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NB - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYC - 1);
  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ARST_W-1:0] ARST_MAX = ARST_W'(ARST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ARST  = 3'd4,
    S_SEND  = 3'd5,
    S_TXW   = 3'd6
  } state_t;

  // Saturating increment for the error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_t state_q, state_d;

  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] ai_data_q, ai_data_d;
  logic              done_prev_q, done_prev_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ARST_W-1:0] arst_q, arst_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [CNT_W-1:0]  tx_left_q, tx_left_d;
  logic              tx_err_q, tx_err_d;
  logic [1:0]        guard_q, guard_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [7:0]        txd_data_q, txd_data_d;
  logic              txd_start_q, txd_start_d;
  logic              ai_start_q, ai_start_d;
  logic              ai_rstn_q, ai_rstn_d;
  logic              busy_q, busy_d;

  // Events shared by the next-state and datapath logic
  logic              hdr_seen_s;
  logic              rx_last_s;
  logic              gap_expire_s;
  logic              ai_done_edge_s;
  logic              wd_expire_s;
  logic              arst_last_s;
  logic              guard_done_s;
  logic              tx_more_s;
  logic [DATA_W-1:0] rx_next_s;
  logic [DATA_W-1:0] tx_shift_s;
  logic [DATA_W-1:0] err_word_s;

  assign hdr_seen_s     = iRXD_Ready && (iRXD_DATA == HDR_BYTE);
  assign rx_last_s      = (rx_cnt_q == LAST_IDX);
  assign gap_expire_s   = (gap_q == GAP_MAX);
  assign ai_done_edge_s = iAI_Done && !done_prev_q;
  assign wd_expire_s    = (wd_q == WD_MAX);
  assign arst_last_s    = (arst_q == ARST_MAX);
  assign guard_done_s   = (guard_q == 2'd2);
  assign tx_more_s      = (tx_left_q != {CNT_W{1'b0}});
  // First received byte ends up in the MSB once the frame is complete
  assign rx_next_s      = (rx_sr_q << 4'd8) | DATA_W'(iRXD_DATA);
  assign tx_shift_s     = tx_sr_q << 4'd8;
  assign err_word_s     = DATA_W'(ERR_BYTE) << (DATA_W - 8);

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hdr_seen_s) begin
          state_d = S_RECV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (iRXD_Ready) begin
          if (rx_last_s) begin
            state_d = S_START;
          end else begin
            state_d = S_RECV;
          end
        end else if (gap_expire_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECV;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A done edge takes priority over a watchdog expiry in the same cycle
        if (ai_done_edge_s) begin
          state_d = S_SEND;
        end else if (wd_expire_s) begin
          state_d = S_ARST;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ARST: begin
        if (arst_last_s) begin
          state_d = S_SEND;
        end else begin
          state_d = S_ARST;
        end
      end
      S_SEND: state_d = S_TXW;
      S_TXW: begin
        if (guard_done_s && iTXD_Done) begin
          if (tx_more_s) begin
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_TXW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; every output is registered one cycle after its state
  always_comb begin
    ai_start_d  = 1'b0;
    txd_start_d = 1'b0;
    txd_data_d  = txd_data_q;
    ai_rstn_d   = 1'b1;
    busy_d      = 1'b1;
    case (state_q)
      S_IDLE:  busy_d = 1'b0;
      S_START: ai_start_d = 1'b1;
      S_ARST:  ai_rstn_d = 1'b0;
      S_SEND: begin
        txd_start_d = 1'b1;
        txd_data_d  = tx_sr_q[DATA_W-1 -: 8];
      end
      default: busy_d = 1'b1;
    endcase
  end

  // Datapath: frame assembly, timers, response shifting and counters
  always_comb begin
    rx_sr_d     = rx_sr_q;
    rx_cnt_d    = rx_cnt_q;
    gap_d       = gap_q;
    ai_data_d   = ai_data_q;
    done_prev_d = iAI_Done;
    wd_d        = wd_q;
    arst_d      = arst_q;
    tx_sr_d     = tx_sr_q;
    tx_left_d   = tx_left_q;
    tx_err_d    = tx_err_q;
    guard_d     = guard_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        rx_sr_d  = {DATA_W{1'b0}};
        rx_cnt_d = {CNT_W{1'b0}};
        gap_d    = {GAP_W{1'b0}};
      end
      S_RECV: begin
        if (iRXD_Ready) begin
          rx_sr_d = rx_next_s;
          gap_d   = {GAP_W{1'b0}};
          if (rx_last_s) begin
            ai_data_d = rx_next_s;
            rx_cnt_d  = {CNT_W{1'b0}};
          end else begin
            rx_cnt_d  = rx_cnt_q + 1'b1;
          end
        end else if (gap_expire_s) begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_START: begin
        wd_d = {WD_W{1'b0}};
      end
      S_WAIT: begin
        if (ai_done_edge_s) begin
          tx_sr_d   = iAI_DATA;
          tx_left_d = LAST_IDX;
          tx_err_d  = 1'b0;
        end else if (wd_expire_s) begin
          err_cnt_d = sat_inc8(err_cnt_q);
          arst_d    = {ARST_W{1'b0}};
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_ARST: begin
        if (arst_last_s) begin
          tx_sr_d   = err_word_s;
          tx_left_d = {CNT_W{1'b0}};
          tx_err_d  = 1'b1;
        end else begin
          arst_d = arst_q + 1'b1;
        end
      end
      S_SEND: begin
        guard_d = 2'd0;
      end
      S_TXW: begin
        if (!guard_done_s) begin
          guard_d = guard_q + 2'd1;
        end else if (iTXD_Done) begin
          if (tx_more_s) begin
            tx_sr_d   = tx_shift_s;
            tx_left_d = tx_left_q - 1'b1;
          end else if (!tx_err_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end else begin
          guard_d = guard_q;
        end
      end
      default: begin
        rx_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rx_sr_q     <= {DATA_W{1'b0}};
      rx_cnt_q    <= {CNT_W{1'b0}};
      gap_q       <= {GAP_W{1'b0}};
      ai_data_q   <= {DATA_W{1'b0}};
      done_prev_q <= 1'b0;
      wd_q        <= {WD_W{1'b0}};
      arst_q      <= {ARST_W{1'b0}};
      tx_sr_q     <= {DATA_W{1'b0}};
      tx_left_q   <= {CNT_W{1'b0}};
      tx_err_q    <= 1'b0;
      guard_q     <= 2'd0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
      txd_data_q  <= 8'd0;
      txd_start_q <= 1'b0;
      ai_start_q  <= 1'b0;
      ai_rstn_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      rx_sr_q     <= rx_sr_d;
      rx_cnt_q    <= rx_cnt_d;
      gap_q       <= gap_d;
      ai_data_q   <= ai_data_d;
      done_prev_q <= done_prev_d;
      wd_q        <= wd_d;
      arst_q      <= arst_d;
      tx_sr_q     <= tx_sr_d;
      tx_left_q   <= tx_left_d;
      tx_err_q    <= tx_err_d;
      guard_q     <= guard_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      txd_data_q  <= txd_data_d;
      txd_start_q <= txd_start_d;
      ai_start_q  <= ai_start_d;
      ai_rstn_q   <= ai_rstn_d;
      busy_q      <= busy_d;
    end
  end

  assign oTXD_DATA  = txd_data_q;
  assign oTXD_Start = txd_start_q;
  assign oAI_DATA   = ai_data_q;
  assign oAI_Start  = ai_start_q;
  assign oAI_RSTn   = ai_rstn_q;
  assign oBusy      = busy_q;
  assign oFrameCnt  = frame_cnt_q;
  assign oErrCnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_ai_frame_bridge.sv
// Bench for uart_ai_frame_bridge: a table of frames on a 64-bit instance,
// plus hand sequences for the gap abort, the watchdog, dropped bytes and a
// 16-bit instance reset mid-transmit.
module tb_uart_ai_frame_bridge;

  logic        clk;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  // 64-bit instance
  logic        rst = 1'b1;
  logic [7:0]  rxd_data = 8'h00;
  logic        rxd_ready = 1'b0;
  logic [7:0]  txd_data;
  logic        txd_start;
  logic        txd_done = 1'b1;
  logic [63:0] ai_data_o;
  logic        ai_start;
  logic [63:0] ai_result = 64'h0;
  logic        ai_done = 1'b0;
  logic        ai_rstn;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  // 16-bit instance
  logic        rst2 = 1'b1;
  logic [7:0]  rxd_data2 = 8'h00;
  logic        rxd_ready2 = 1'b0;
  logic [7:0]  txd_data2;
  logic        txd_start2;
  logic        txd_done2 = 1'b1;
  logic [15:0] ai_data2;
  logic        ai_start2;
  logic [15:0] ai_result2 = 16'h0;
  logic        ai_done2 = 1'b0;
  logic        ai_rstn2;
  logic        busy2;
  logic [15:0] frame_cnt2;
  logic [7:0]  err_cnt2;

  uart_ai_frame_bridge #(.DATA_W(64), .GAP_CYC(100), .TIMEOUT_CYC(200)) dut (
    .iCLK(clk), .iRST(rst), .iRXD_DATA(rxd_data), .iRXD_Ready(rxd_ready),
    .oTXD_DATA(txd_data), .oTXD_Start(txd_start), .iTXD_Done(txd_done),
    .oAI_DATA(ai_data_o), .oAI_Start(ai_start), .iAI_DATA(ai_result),
    .iAI_Done(ai_done), .oAI_RSTn(ai_rstn), .oBusy(busy),
    .oFrameCnt(frame_cnt), .oErrCnt(err_cnt)
  );

  uart_ai_frame_bridge #(.DATA_W(16), .GAP_CYC(100), .TIMEOUT_CYC(200)) dut16 (
    .iCLK(clk), .iRST(rst2), .iRXD_DATA(rxd_data2), .iRXD_Ready(rxd_ready2),
    .oTXD_DATA(txd_data2), .oTXD_Start(txd_start2), .iTXD_Done(txd_done2),
    .oAI_DATA(ai_data2), .oAI_Start(ai_start2), .iAI_DATA(ai_result2),
    .iAI_Done(ai_done2), .oAI_RSTn(ai_rstn2), .oBusy(busy2),
    .oFrameCnt(frame_cnt2), .oErrCnt(err_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment models for the 64-bit instance (sole writer of these vars)
  int          start_cnt = 0;
  int          tx_n = 0;
  int          rstn_low_cnt = 0;
  int          cyc = 0;
  int          last_start_cyc = 0;
  int          low_start_cyc = 0;
  int          tx_busy = 0;
  int          ai_cd = 0;
  int          ai_hold = 0;
  logic        prev_rstn = 1'b1;
  logic [7:0]  tx_log [0:255];
  // Written only by the main sequence
  int          ai_mode = 0;          // 0: answer 10 cycles after start, 1: done stuck high
  logic [63:0] model_result = 64'h0;

  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (ai_start === 1'b1) begin
        start_cnt = start_cnt + 1;
        last_start_cyc = cyc;
      end
      if (ai_rstn === 1'b0) begin
        rstn_low_cnt = rstn_low_cnt + 1;
        if (prev_rstn === 1'b1) low_start_cyc = cyc;
      end
      prev_rstn = ai_rstn;
      if (txd_start === 1'b1) begin
        if (tx_n < 256) tx_log[tx_n] = txd_data;
        tx_n = tx_n + 1;
        txd_done = 1'b0;
        tx_busy = 5;
      end else if (tx_busy > 0) begin
        tx_busy = tx_busy - 1;
        if (tx_busy == 0) txd_done = 1'b1;
      end
      if (ai_mode == 1) begin
        ai_done = 1'b1;
        ai_cd = 0;
        ai_hold = 0;
      end else begin
        if (ai_start === 1'b1) begin
          ai_cd = 10;
        end else if (ai_cd > 0) begin
          ai_cd = ai_cd - 1;
          if (ai_cd == 0) ai_hold = 3;
        end else if (ai_hold > 0) begin
          ai_hold = ai_hold - 1;
        end
        ai_done = (ai_hold > 0);
        ai_result = model_result;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    int          npre;
    logic [7:0]  pre [2];
    logic [7:0]  pl  [8];
    logic [63:0] ai_res;
    logic [63:0] exp_ai;
  } frame_vec_t;

  frame_vec_t vec [4];
  int         exp_frames = 0;
  int         exp_errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt = vec_cnt + 1;
    if (act !== exp) begin
      miss_cnt = miss_cnt + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxd_data = b;
    rxd_ready = 1'b1;
    @(negedge clk);
    rxd_ready = 1'b0;
  endtask

  task automatic send_byte2(input logic [7:0] b);
    @(negedge clk);
    rxd_data2 = b;
    rxd_ready2 = 1'b1;
    @(negedge clk);
    rxd_ready2 = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input int idx);
    for (int i = 0; i < vec[idx].npre; i++) send_byte(vec[idx].pre[i]);
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) send_byte(vec[idx].pl[i]);
  endtask

  task automatic run_frame(input int idx);
    int          base_tx;
    int          base_st;
    bit          ok;
    logic [63:0] r;
    base_tx = tx_n;
    base_st = start_cnt;
    model_result = vec[idx].ai_res;
    send_frame(idx);
    @(negedge clk);
    chk($sformatf("v%0d_start_latency", idx), 64'(ai_start), 64'h1);
    wait_idle(400, ok);
    chk($sformatf("v%0d_idle_timeout", idx), 64'(ok), 64'h1);
    exp_frames = exp_frames + 1;
    chk($sformatf("v%0d_ai_data", idx), ai_data_o, vec[idx].exp_ai);
    chk($sformatf("v%0d_start_pulses", idx), 64'(start_cnt - base_st), 64'h1);
    chk($sformatf("v%0d_tx_count", idx), 64'(tx_n - base_tx), 64'h8);
    r = vec[idx].ai_res;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d_tx_byte%0d", idx, i), 64'(tx_log[base_tx + i]), 64'(r[63 - 8*i -: 8]));
    end
    chk($sformatf("v%0d_frame_cnt", idx), 64'(frame_cnt), 64'(exp_frames));
    chk($sformatf("v%0d_err_cnt", idx), 64'(err_cnt), 64'(exp_errs));
  endtask

  initial begin
    int          base_tx;
    int          base_st;
    int          base_low;
    int          n;
    bit          ok;
    logic [63:0] r;

    vec[0].npre = 0; vec[0].pre = '{8'h00, 8'h00};
    vec[0].pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    vec[0].ai_res = 64'h1122334455667788; vec[0].exp_ai = 64'h0102030405060708;
    vec[1].npre = 2; vec[1].pre = '{8'h00, 8'hFF};
    vec[1].pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    vec[1].ai_res = 64'h1122334455667788; vec[1].exp_ai = 64'h0102030405060708;
    vec[2].npre = 0; vec[2].pre = '{8'h00, 8'h00};
    vec[2].pl = '{8'hA5, 8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h3C, 8'hC3, 8'hA5};
    vec[2].ai_res = 64'hDEADBEEFCAFEF00D; vec[2].exp_ai = 64'hA5A500FF5A3CC3A5;
    vec[3].npre = 1; vec[3].pre = '{8'h5A, 8'h00};
    vec[3].pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec[3].ai_res = 64'h0000000000000001; vec[3].exp_ai = 64'hFFFFFFFFFFFFFFFF;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    chk("rst_txd_start", 64'(txd_start), 64'h0);
    chk("rst_txd_data", 64'(txd_data), 64'h0);
    chk("rst_ai_start", 64'(ai_start), 64'h0);
    chk("rst_ai_data", ai_data_o, 64'h0);
    chk("rst_ai_rstn", 64'(ai_rstn), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'h0);
    chk("rst_err_cnt", 64'(err_cnt), 64'h0);

    // Table of normal frames (noise before header, header byte as data)
    for (int v = 0; v < 4; v++) begin
      run_frame(v);
      repeat (3) @(negedge clk);
    end

    // Gap abort after 3 payload bytes
    base_st = start_cnt;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (90) @(negedge clk);
    chk("gap_still_busy", 64'(busy), 64'h1);
    repeat (15) @(negedge clk);
    exp_errs = exp_errs + 1;
    chk("gap_idle", 64'(busy), 64'h0);
    chk("gap_err_cnt", 64'(err_cnt), 64'(exp_errs));
    chk("gap_no_start", 64'(start_cnt - base_st), 64'h0);
    chk("gap_ai_data_kept", ai_data_o, vec[3].exp_ai);
    chk("gap_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    run_frame(0);

    // Watchdog: done stuck high, never a rising edge
    ai_mode = 1;
    repeat (3) @(negedge clk);
    base_tx = tx_n;
    base_st = start_cnt;
    base_low = rstn_low_cnt;
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) send_byte(vec[2].pl[i]);
    wait_idle(600, ok);
    exp_errs = exp_errs + 1;
    chk("wd_idle_timeout", 64'(ok), 64'h1);
    chk("wd_start_pulses", 64'(start_cnt - base_st), 64'h1);
    chk("wd_rstn_low_cycles", 64'(rstn_low_cnt - base_low), 64'h4);
    chk("wd_rstn_delay", 64'(low_start_cyc - last_start_cyc), 64'd201);
    chk("wd_tx_count", 64'(tx_n - base_tx), 64'h1);
    chk("wd_tx_byte", 64'(tx_log[base_tx]), 64'hEE);
    chk("wd_err_cnt", 64'(err_cnt), 64'(exp_errs));
    chk("wd_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("wd_ai_data", ai_data_o, vec[2].exp_ai);
    ai_mode = 0;
    repeat (3) @(negedge clk);

    // Bytes during S_WAIT and S_TXW are dropped
    base_tx = tx_n;
    base_st = start_cnt;
    model_result = vec[2].ai_res;
    send_frame(2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_n > base_tx) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drop_first_tx_timeout", 64'(ok), 64'h1);
    send_byte(8'hA5);
    send_byte(8'h33);
    wait_idle(400, ok);
    exp_frames = exp_frames + 1;
    chk("drop_idle_timeout", 64'(ok), 64'h1);
    chk("drop_start_pulses", 64'(start_cnt - base_st), 64'h1);
    chk("drop_tx_count", 64'(tx_n - base_tx), 64'h8);
    r = vec[2].ai_res;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drop_tx_byte%0d", i), 64'(tx_log[base_tx + i]), 64'(r[63 - 8*i -: 8]));
    end
    chk("drop_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("drop_err_cnt", 64'(err_cnt), 64'(exp_errs));
    repeat (5) @(negedge clk);
    chk("drop_still_idle", 64'(busy), 64'h0);
    run_frame(1);

    // 16-bit instance: assemble BEEF, then reset while transmitting
    send_byte2(8'hA5);
    send_byte2(8'hBE);
    send_byte2(8'hEF);
    @(negedge clk);
    chk("w16_start", 64'(ai_start2), 64'h1);
    chk("w16_ai_data", 64'(ai_data2), 64'hBEEF);
    repeat (3) @(negedge clk);
    ai_result2 = 16'h1234;
    ai_done2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd_start2 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("w16_tx_seen", 64'(ok), 64'h1);
    chk("w16_tx_byte0", 64'(txd_data2), 64'h12);
    rst2 = 1'b1;
    @(negedge clk);
    chk("w16_rst_txd_start", 64'(txd_start2), 64'h0);
    chk("w16_rst_txd_data", 64'(txd_data2), 64'h0);
    chk("w16_rst_ai_data", 64'(ai_data2), 64'h0);
    chk("w16_rst_ai_start", 64'(ai_start2), 64'h0);
    chk("w16_rst_ai_rstn", 64'(ai_rstn2), 64'h1);
    chk("w16_rst_busy", 64'(busy2), 64'h0);
    chk("w16_rst_frame_cnt", 64'(frame_cnt2), 64'h0);
    chk("w16_rst_err_cnt", 64'(err_cnt2), 64'h0);
    rst2 = 1'b0;
    ai_done2 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd_start2 === 1'b1) n = n + 1;
    end
    chk("w16_no_tx_after_rst", 64'(n), 64'h0);
    chk("w16_idle_after_rst", 64'(busy2), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
